// File: rtl/stringgen_pkg.sv
// Shared definitions for the serial string generator: state encoding,
// default sizing and the effective-length helper.
package stringgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int WIDTH_DEF     = 16;
    localparam int COUNT_MAX_DEF = 9999;
    localparam int COUNT_W       = 14;
    localparam int LEN_W         = 5;

    // A length of zero, or one longer than the pattern, means "whole pattern".
    function automatic int eff_len(input int len_v, input int width_v);
        int r;
        if ((len_v == 0) || (len_v > width_v)) begin
            r = width_v;
        end else begin
            r = len_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/stringgen_shift.sv
// Shadow pattern store and bit index countdown for the string generator.
// The pattern is held LSB-aligned; bits leave from shadow[len-1] down to shadow[0].
module stringgen_shift
    import stringgen_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int LEN_EFF_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     pattern_i,
    input  logic [LEN_EFF_W-1:0] len_i,
    input  logic                 advance_i,
    input  logic                 wrap_i,
    output logic                 bit_o,
    output logic                 last_o
);

    logic [WIDTH-1:0]     shadow_q, shadow_d;
    logic [LEN_EFF_W-1:0] len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    // Next-state: capture on load, count down on each emitted bit, wrap when repeating.
    always_comb begin
        shadow_d = shadow_q;
        len_d    = len_q;
        idx_d    = idx_q;
        if (load_i) begin
            shadow_d = pattern_i;
            len_d    = len_i;
            idx_d    = IDX_W'(len_i - LEN_EFF_W'(1));
        end else if (advance_i) begin
            if (idx_q == IDX_W'(0)) begin
                if (wrap_i) begin
                    idx_d = IDX_W'(len_q - LEN_EFF_W'(1));
                end else begin
                    idx_d = idx_q;
                end
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            shadow_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
        end
    end

    assign bit_o  = shadow_q[idx_q];
    assign last_o = (idx_q == IDX_W'(0));

endmodule

// File: rtl/stringgen_wfs.sv
// Serial bit-string generator: sends a captured pattern MSB-first on tick
// strobes, with pause/resume, optional continuous repeat and a saturating
// count of emitted bits.
module stringgen_wfs
    import stringgen_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int COUNT_MAX = COUNT_MAX_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               en,
    input  logic               tick,
    input  logic [WIDTH-1:0]   pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               rpt,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] sent_count
);

    localparam int LEN_EFF_W = $clog2(WIDTH + 1);
    localparam logic [COUNT_W-1:0] CNT_SAT = COUNT_W'(COUNT_MAX);

    state_e               state_q, state_d;
    logic                 bit_out_q, bit_out_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 load_s;
    logic                 emit_s;
    logic                 bit_sel_s;
    logic                 last_s;
    logic [LEN_EFF_W-1:0] len_eff_s;

    assign len_eff_s = LEN_EFF_W'(eff_len(int'(len), WIDTH));

    stringgen_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_i     (clk),
        .clr_i     (clr),
        .load_i    (load_s),
        .pattern_i (pattern),
        .len_i     (len_eff_s),
        .advance_i (emit_s),
        .wrap_i    (rpt),
        .bit_o     (bit_sel_s),
        .last_o    (last_s)
    );

    // FSM next-state; pause request takes priority over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        emit_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (en) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    emit_s = 1'b1;
                    if (last_s && !rpt) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_PAUSE: begin
                if (en) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and counter next values, all registered so they align with the state.
    always_comb begin
        bit_out_d   = bit_out_q;
        bit_valid_d = emit_s;
        busy_d      = (state_d == ST_SEND) || (state_d == ST_PAUSE);
        done_d      = (state_d == ST_DONE);
        cnt_d       = cnt_q;
        if (emit_s) begin
            bit_out_d = bit_sel_s;
            if (cnt_q < CNT_SAT) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            bit_out_d = bit_out_q;
        end
    end

    // State, output and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = cnt_q;

endmodule

// File: tb/tb_stringgen_wfs.sv
// Self-checking bench for stringgen_wfs: expected bit streams are generated
// from the pattern/length and queued, observed strobed bits are queued by a
// monitor, and each scenario task compares the two.
module tb_stringgen_wfs;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        en;
    logic        tick;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        rpt;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic [13:0] sent_count;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   exp_cnt = 0;
    logic exp_q[$];
    logic obs_q[$];

    stringgen_wfs dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .en         (en),
        .tick       (tick),
        .pattern    (pattern),
        .len        (len),
        .rpt        (rpt),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    // Monitor: collect strobed bits and done pulses away from the active edge.
    always @(negedge clk) begin
        if (!clr && bit_valid) obs_q.push_back(bit_out);
        if (!clr && done) done_seen++;
    end

    // One clock of stimulus; pulses are dropped again just after the edge.
    task automatic cyc(input logic s, input logic e, input logic t);
        start = s; en = e; tick = t;
        @(posedge clk); #1;
        start = 1'b0; en = 1'b0; tick = 1'b0;
    endtask

    // Reference model: bits leave from p[n-1] down to p[0].
    task automatic push_bits(input logic [15:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(p[i]);
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; en = 1'b0; tick = 1'b0; rpt = 1'b0;
        pattern = 16'h0000; len = 5'd0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        n_chk++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000 || sent_count !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%b vld=%b busy=%b done=%b cnt=%0d, want all 0",
                     bit_out, bit_valid, busy, done, sent_count);
        end
        clr = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        logic [15:0] pats [3] = '{16'h000B, 16'hB000, 16'h00C3};
        int          lens [3] = '{4, 4, 8};
        logic        e, o;
        for (int k = 0; k < 3; k++) begin
            done_seen = 0;
            pattern = pats[k]; len = 5'(lens[k]); rpt = 1'b0;
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL basic_busy[%0d]: got %b want 1", k, busy);
            end
            push_bits(pats[k], lens[k]);
            exp_cnt += lens[k];
            for (int i = 0; i < lens[k]; i++) cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            n_chk++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL basic_nbits[%0d]: got %0d want %0d", k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
                if (o !== e) begin n_fail++; $display("FAIL basic_bit[%0d]: got %b want %b", k, o, e); end
            end
            exp_q.delete(); obs_q.delete();
            n_chk++;
            if (done_seen != 1 || busy !== 1'b0 || bit_valid !== 1'b0 || sent_count !== 14'(exp_cnt)) begin
                n_fail++;
                $display("FAIL basic_end[%0d]: got done=%0d busy=%b vld=%b cnt=%0d want 1,0,0,%0d",
                         k, done_seen, busy, bit_valid, sent_count, exp_cnt);
            end
            n_chk++;
            if (bit_out !== pats[k][0]) begin
                n_fail++; $display("FAIL basic_hold[%0d]: got %b want %b", k, bit_out, pats[k][0]);
            end
        end
    endtask

    task automatic test_len_full();
        int   lens [3] = '{0, 20, 16};
        logic e, o;
        for (int k = 0; k < 3; k++) begin
            done_seen = 0;
            pattern = 16'h8001; len = 5'(lens[k]); rpt = 1'b0;
            cyc(1'b1, 1'b0, 1'b0);
            push_bits(16'h8001, 16);
            for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            n_chk++;
            if (obs_q.size() != 16 || done_seen != 1) begin
                n_fail++; $display("FAIL lenfull_count[len=%0d]: got %0d bits %0d done want 16 bits 1 done",
                                   lens[k], obs_q.size(), done_seen);
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
                if (o !== e) begin n_fail++; $display("FAIL lenfull_bit[len=%0d]: got %b want %b", lens[k], o, e); end
            end
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_rpt();
        logic e, o;
        done_seen = 0;
        pattern = 16'h0005; len = 5'd3; rpt = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) push_bits(16'h0005, 3);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) pattern = 16'h0002;
            cyc(1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (done_seen != 0 || busy !== 1'b1 || obs_q.size() != 9) begin
            n_fail++; $display("FAIL rpt_running: got done=%0d busy=%b bits=%0d want 0,1,9",
                               done_seen, busy, obs_q.size());
        end
        rpt = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (done_seen != 1 || busy !== 1'b0 || obs_q.size() != 12) begin
            n_fail++; $display("FAIL rpt_stop: got done=%0d busy=%b bits=%0d want 1,0,12",
                               done_seen, busy, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL rpt_bit: got %b want %b", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pause();
        logic e, o;
        done_seen = 0;
        cyc(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_idle_en: got busy=%b want 0", busy); end
        pattern = 16'h00A5; len = 5'd8; rpt = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        push_bits(16'h00A5, 8);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        pattern = 16'h0F0F;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pause_hold: got bits=%0d busy=%b want 2,1", obs_q.size(), busy);
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL pause_en_tick: got bits=%0d want 4", obs_q.size());
        end
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 8 || done_seen != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL pause_end: got bits=%0d done=%0d busy=%b want 8,1,0",
                               obs_q.size(), done_seen, busy);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL pause_bit: got %b want %b", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic e, o;
        done_seen = 0;
        pattern = 16'h0005; len = 5'd3; rpt = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        push_bits(16'h0005, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        pattern = 16'h0006;
        cyc(1'b1, 1'b0, 1'b0);
        push_bits(16'h0006, 3);
        pattern = 16'h0001;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 6 || done_seen != 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got bits=%0d done=%0d busy=%b want 6,2,0",
                               obs_q.size(), done_seen, busy);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_bit: got %b want %b", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clr_mid();
        logic e, o;
        pattern = 16'h000B; len = 5'd4; rpt = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        push_bits(16'h0003 << 2, 2);
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        n_chk++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL clr_pre: got vld=%b out=%b busy=%b want 1,1,1", bit_valid, bit_out, busy);
        end
        clr = 1'b1;
        #1;
        n_chk++;
        if ({bit_out, bit_valid, busy, done} !== 4'b0000 || sent_count !== 14'd0) begin
            n_fail++;
            $display("FAIL clr_immediate: got out=%b vld=%b busy=%b done=%b cnt=%0d want all 0",
                     bit_out, bit_valid, busy, done, sent_count);
        end
        cyc(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL clr_bits_before: got %0d want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL clr_bit_before: got %b want %b", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        done_seen = 0;
        cyc(1'b1, 1'b0, 1'b0);
        push_bits(16'h000B, 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs_q.size() != 4 || done_seen != 1 || sent_count !== 14'd4) begin
            n_fail++; $display("FAIL clr_resend: got bits=%0d done=%0d cnt=%0d want 4,1,4",
                               obs_q.size(), done_seen, sent_count);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL clr_resend_bit: got %b want %b", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturate();
        clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        pattern = 16'hFFFF; len = 5'd0; rpt = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b1);
        n_chk++;
        if (sent_count !== 14'd100) begin
            n_fail++; $display("FAIL sat_mid: got %0d want 100", sent_count);
        end
        for (int i = 100; i < 10005; i++) cyc(1'b0, 1'b0, 1'b1);
        n_chk++;
        if (sent_count !== 14'd9999 || bit_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold: got cnt=%0d vld=%b busy=%b want 9999,1,1",
                               sent_count, bit_valid, busy);
        end
        obs_q.delete();
        clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        rpt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_full();
        test_rpt();
        test_pause();
        test_back_to_back();
        test_clr_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
